// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and helpers for the SRAM round-robin arbiter
// Contents:
//   clog2_min1  - index width for n items, never below 1 bit
//   MAX_REQ     - largest requester count the response tag can name
//   IDX_WIDTH   - requester tag width carried through the response tracker
//   rsp_entry_t - one in-flight access: {valid, idx}
package sram_arb_pkg;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned IDX_WIDTH = clog2_min1(MAX_REQ);

  // The tag is sized for MAX_REQ; tags are zero-extended requester indices,
  // so bits above clog2(NUM_REQ) are constant zero in any instance.
  typedef struct packed {
    logic                 valid;
    logic [IDX_WIDTH-1:0] idx;
  } rsp_entry_t;

endpackage

// File: rtl/sram_rsp_tracker.sv
// rtl/sram_rsp_tracker.sv - LATENCY-deep tag pipeline returning responses to their owner
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   push_valid_i   - an access was granted this cycle
//   push_idx_i     - requester index owning that access
//   rvalid_o       - one-hot response valid, LATENCY cycles after the push
module sram_rsp_tracker
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned LATENCY = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_valid_i,
  input  logic [IDX_WIDTH-1:0] push_idx_i,
  output logic [NUM_REQ-1:0]   rvalid_o
);

  rsp_entry_t pipe_q [LATENCY];

  // Idle cycles push valid=0 so every slot tracks exactly one macro cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0].valid <= push_valid_i;
      pipe_q[0].idx   <= push_idx_i;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pipe_q[LATENCY-1].valid && (pipe_q[LATENCY-1].idx == IDX_WIDTH'(i))) begin
        rvalid_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - round-robin sharing of one single-port SRAM macro
// Ports:
//   clk_i, rst_ni        - clock (shared with macro), asynchronous active-low reset
//   req_i, gnt_o         - per-requester request / one-hot grant (combinational)
//   addr_i, we_i         - per-requester word address and write enable
//   wdata_i, strb_i      - per-requester write data and byte enables
//   rvalid_o, rdata_o    - per-requester response valid and broadcast read data
//   mem_csb_o, mem_web_o - macro chip select / write enable, active low
//   mem_wmask_o          - macro byte mask
//   mem_addr_o           - macro address
//   mem_din_o, mem_dout_i - macro write / read data
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_REQ-1:0]               req_i,
  output logic [NUM_REQ-1:0]               gnt_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_i,
  input  logic [NUM_REQ-1:0]               we_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  strb_i,
  output logic [NUM_REQ-1:0]               rvalid_o,
  output logic [NUM_REQ*DATA_WIDTH-1:0]    rdata_o,
  output logic                             mem_csb_o,
  output logic                             mem_web_o,
  output logic [DATA_WIDTH/8-1:0]          mem_wmask_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [DATA_WIDTH-1:0]            mem_din_o,
  input  logic [DATA_WIDTH-1:0]            mem_dout_i
);

  localparam int unsigned RR_W   = clog2_min1(NUM_REQ);
  localparam int unsigned CAND_W = RR_W + 1;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [RR_W-1:0]   rr_q, rr_d;
  logic [RR_W-1:0]   winner;
  logic [CAND_W-1:0] cand;
  logic              found;
  logic              grant;

  // Search from rr_q upward with wrap. rr_q < NUM_REQ and offset < NUM_REQ,
  // so a single conditional subtract replaces the modulo.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, rr_q} + CAND_W'(off);
      if (cand >= CAND_W'(NUM_REQ)) begin
        cand = cand - CAND_W'(NUM_REQ);
      end
      if (!found && req_i[cand[RR_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[RR_W-1:0];
      end
    end
  end

  // Requests are ignored while reset is held so nothing reaches the macro.
  assign grant = found & rst_ni;

  always_comb begin
    rr_d = rr_q;
    if (grant) begin
      rr_d = (winner == RR_W'(NUM_REQ - 1)) ? '0 : winner + RR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  always_comb begin
    gnt_o       = '0;
    mem_csb_o   = 1'b1;
    mem_web_o   = 1'b1;
    mem_wmask_o = '0;
    mem_addr_o  = '0;
    mem_din_o   = '0;
    if (grant) begin
      gnt_o[winner] = 1'b1;
      mem_csb_o     = 1'b0;
      mem_web_o     = ~we_i[winner];
      mem_wmask_o   = strb_i[winner*STRB_W +: STRB_W];
      mem_addr_o    = addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
      mem_din_o     = wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  sram_rsp_tracker #(
    .NUM_REQ (NUM_REQ),
    .LATENCY (LATENCY)
  ) u_rsp_tracker (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_valid_i (grant),
    .push_idx_i   (IDX_WIDTH'(winner)),
    .rvalid_o     (rvalid_o)
  );

  assign rdata_o = {NUM_REQ{mem_dout_i}};

endmodule

// File: doc/sram_rr_arbiter.md
# sram_rr_arbiter

Round-robin arbiter that shares one synchronous single-port SRAM macro (active-low chip select/write enable, e.g. the 1 kB 32x256 macro's RW port) between several memory-stream requesters, such as an AXI-to-memory bridge and a DMA or debug port. It grants at most one request per cycle and drives the macro pins directly. It tracks which requester owns each in-flight access and returns the response valid and read data to that requester after the macro's fixed latency.

## Interface
- NUM_REQ, default 2: number of requesters, at least 1.
- ADDR_WIDTH, default 8: word address width at the macro.
- DATA_WIDTH, default 32: data width. Must be a multiple of 8.
- LATENCY, default 1: macro read latency in cycles, at least 1.
- clk_i  in  1  clock, used by both this block and the macro.
- rst_ni  in  1  asynchronous reset, active low.
- req_i  in  NUM_REQ  per-requester request valid.
- gnt_o  out  NUM_REQ  per-requester grant, one-hot or zero.
- addr_i  in  NUM_REQ x ADDR_WIDTH  word address.
- we_i  in  NUM_REQ  write enable, active high.
- wdata_i  in  NUM_REQ x DATA_WIDTH  write data.
- strb_i  in  NUM_REQ x DATA_WIDTH/8  byte enables.
- rvalid_o  out  NUM_REQ  response valid, returned for reads and writes.
- rdata_o  out  NUM_REQ x DATA_WIDTH  read data, qualified by rvalid_o.
- mem_csb_o  out  1  macro chip select, active low.
- mem_web_o  out  1  macro write enable, active low.
- mem_wmask_o  out  DATA_WIDTH/8  macro byte mask.
- mem_addr_o  out  ADDR_WIDTH  macro address.
- mem_din_o  out  DATA_WIDTH  macro write data.
- mem_dout_i  in  DATA_WIDTH  macro read data.

## Operation
- **Priority pointer.** rr_q has width clog2(NUM_REQ) (minimum 1) and resets to 0. The winner is the first requester with req_i set, searching from index rr_q upward and wrapping modulo NUM_REQ.
- **Grant.** gnt_o[winner]=1 in the same cycle. The grant is combinational from req_i and rr_q only; no path from gnt_o to req_i is allowed.
- **Pointer update.** On a grant to index k, rr_q <= (k+1) mod NUM_REQ. With no request, rr_q holds.
- **Memory pins on a grant.** mem_csb_o=0; mem_web_o=!we_i[k]; mem_addr_o, mem_din_o and mem_wmask_o take requester k's fields.
- **Memory pins when idle.** mem_csb_o=1, mem_web_o=1, all other memory outputs 0.
- **Response tracking.** Each grant pushes {valid=1, idx=k} into a LATENCY-deep shift register; idle cycles push valid=0. When an entry emerges at the tail with valid=1, rvalid_o[idx]=1 for exactly one cycle.
- **Read data.** rdata_o of every requester is mem_dout_i (broadcast). Only rvalid_o qualifies it.
- **Back-to-back operation.** One new grant per cycle with no stall. Up to LATENCY accesses are in flight.
- **Single requester.** With NUM_REQ=1 the requester is always granted when it requests, and rr_q stays at 0.
- **Simultaneous events.** A grant and a response in the same cycle are independent. The same requester may be granted while its earlier response returns.
- **Reset mid-operation.** All in-flight entries are cleared and no rvalid_o is issued for them. rr_q returns to 0.
- **Reset values.** gnt_o=0 (since req_i is ignored during reset), rvalid_o=0, rdata_o=mem_dout_i, mem_csb_o=1, mem_web_o=1, other memory outputs 0.

## Timing
- Request to grant: 0 cycles (combinational).
- Grant in cycle t to rvalid_o in cycle t+LATENCY.
- Macro pins are combinational from the grant mux and are sampled by the macro on the clk_i rising edge.
- Fairness: a continuously requesting input waits at most NUM_REQ-1 cycles for a grant.
- Registers: rr_q and the LATENCY x (1 + idx width) tracking shift register. Nothing else is registered.

## Structure
- Package sram_arb_pkg holds IDX_WIDTH = clog2 with a minimum of 1, and the rsp_entry_t struct {valid, idx}.
- Sub-module sram_rsp_tracker implements the LATENCY-deep response shift register and the one-hot rvalid_o decode.
- Top level contains the round-robin search, the grant one-hot, the memory pin mux and the polarity inversion.

## Test plan
- **Reset.** Assert rst_ni=0 with req_i=2'b11 -> gnt_o=0, mem_csb_o=1, rvalid_o=0. Release reset, then first grant goes to index 0.
- **Contention.** NUM_REQ=2, both requesting for 4 cycles -> gnt_o sequence 01,10,01,10. Each rvalid_o follows its grant by 1 cycle.
- **Write then read.** Requester 1 writes addr 0x10, data 0xDEADBEEF, strb 4'b0101 over a zero-initialised macro model. Requester 0 then reads 0x10 -> rvalid_o[0]=1 with rdata 0x00AD00EF. rvalid_o[1] pulses for the write.
- **Pipelining.** LATENCY=2, grants to 0,1,0 on consecutive cycles -> rvalid_o pulses on 0,1,0 in cycles t+2, t+3, t+4.
- **Reset in flight.** Assert rst_ni low one cycle after a grant -> no rvalid_o ever appears for that access.
- **Idle and fairness.** req_i=0 -> csb=1, web=1, rr_q unchanged. With 3 requesters and only index 2 requesting after rr_q=0 -> index 2 is granted and rr_q becomes 0.
